tank_access_sequencer: RTL and testbench
========================================

TANK_ACCESS_SEQUENCER -- requirements
Module: tank_access_sequencer

Interface
REQ-001 SHALL have parameter MINOR_LEN, default 18, meaning digit clocks per minor cycle (one short word slot).
REQ-002 SHALL have parameter WORDS_PER_TANK, default 32, meaning short-word slots per tank recirculation.
REQ-003 SHALL have port clk  input  1  digit clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  access request present.
REQ-006 SHALL have port req_ready  output  1  sequencer can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = write (store), 0 = read (fetch).
REQ-008 SHALL have port req_long  input  1  1 = 36-bit long word (two slots), 0 = short word.
REQ-009 SHALL have port req_addr  input  10  [9:8] rack, [7] f9 (up/down), [6:5] tank within group, [4:0] word slot.
REQ-010 SHALL have port rack_read  output  4  one-hot rack read select, active only during transfer window.
REQ-011 SHALL have port rack_write  output  4  one-hot rack write select, active only during transfer window.
REQ-012 SHALL have port f9_pos  output  1  latched req_addr[7] for the current access.
REQ-013 SHALL have port tank_sel  output  2  latched req_addr[6:5] for the current access.
REQ-014 SHALL have port xfer_gate  output  1  high for exactly the digit clocks of the addressed slot(s).
REQ-015 SHALL have port word_pos  output  5  current recirculation slot number.
REQ-016 SHALL have port digit_pos  output  5  current digit within minor cycle.
REQ-017 SHALL have port done  output  1  one-cycle pulse on access completion.
REQ-018 SHALL have port err  output  1  one-cycle pulse on rejected request.

Function
REQ-019 digit_pos SHALL count 0..MINOR_LEN-1 every clock, wrap to 0; word_pos SHALL increment on digit_pos wrap, modulo WORDS_PER_TANK; counters free-run regardless of state.
REQ-020 States SHALL be IDLE, WAIT_SLOT, XFER, DONE; req_ready high only in IDLE.
REQ-021 Accept SHALL occur when req_valid && req_ready; addr, write, long latched that cycle; next state WAIT_SLOT.
REQ-022 Accepted request with req_long=1 and req_addr[0]=1 SHALL be rejected: err pulses the following cycle, state stays IDLE, no selects asserted.
REQ-023 WAIT_SLOT -> XFER SHALL occur on the first cycle strictly after acceptance where word_pos == latched slot and digit_pos == 0; that cycle is the first XFER cycle.
REQ-024 In XFER, xfer_gate SHALL be 1, and exactly one bit of rack_write (write) or rack_read (read), indexed by latched rack, SHALL be 1; all else 0.
REQ-025 XFER SHALL last MINOR_LEN clocks (short) or 2*MINOR_LEN clocks (long); then DONE for one clock with done=1, then IDLE.
REQ-026 Outside XFER, rack_read, rack_write, xfer_gate SHALL be 0; rack_read and rack_write SHALL never both be nonzero.
REQ-027 Worst-case accept-to-gate latency SHALL be MINOR_LEN*WORDS_PER_TANK clocks (slot just passed); best case 1 clock.
REQ-028 Long access at slot 30 SHALL cover slots 30 and 31 with no wrap issue; slot 31 long is illegal per REQ-022.
REQ-029 req_valid deasserting after acceptance SHALL NOT abort the access; req inputs ignored outside IDLE.
REQ-030 f9_pos and tank_sel SHALL hold their latched values from acceptance until next acceptance.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE, digit_pos=0, word_pos=0, all selects/xfer_gate/done/err=0, f9_pos=0, tank_sel=0, req_ready=1 after release.
REQ-032 Reset mid-XFER SHALL drop all selects on the next edge with no done pulse.

Verification
REQ-033 Short read addr=0x005 accepted at word_pos=3, digit 0 -> rack_read=0001, xfer_gate high word_pos=5 digits 0..17 (18 clocks), done next cycle.
REQ-034 Long write addr=0x3C4 (rack 3, f9=1, tank 2, slot 4) -> rack_write=1000, f9_pos=1, tank_sel=2, gate 36 clocks, slots 4-5.
REQ-035 Request accepted at word_pos=7, digit_pos=0, slot 7 -> wait full 576 clocks, gate starts next pass.
REQ-036 Long request addr slot 9 -> err pulse one cycle, rack_read=rack_write=0, req_ready stays 1.
REQ-037 rst_n low at XFER digit 10 -> selects 0 next edge, counters 0, no done; fresh request then completes normally.
REQ-038 Back-to-back requests with req_valid held high -> second accepted only in IDLE after done cycle; req_ready low throughout first access.

Source files
------------

// File: rtl/tank_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tank_access_sequencer
// Description : Sequences single read/write accesses to a recirculating
//               delay-line store. Free-running digit and word counters track
//               the slot currently passing the heads. An accepted request
//               waits for its slot, then opens a transfer gate for one short
//               slot or two consecutive slots (long word) with the addressed
//               rack selected for read or write.
// Ports       : clk        - digit clock, all state on rising edge
//               rst_n      - synchronous active-low reset
//               req_valid  - request present        req_ready - can accept
//               req_write  - 1 store / 0 fetch      req_long  - 36-bit word
//               req_addr   - [9:8] rack, [7] f9, [6:5] tank, [4:0] slot
//               rack_read  - one-hot rack read select during transfer
//               rack_write - one-hot rack write select during transfer
//               f9_pos     - latched f9 bit         tank_sel  - latched tank
//               xfer_gate  - high for the digit clocks of the addressed slot(s)
//               word_pos   - current slot           digit_pos - current digit
//               done       - completion pulse       err       - reject pulse
// Revision    : 1.0 - initial release
// ============================================================================
module tank_access_sequencer #(
  parameter int MINOR_LEN      = 18,
  parameter int WORDS_PER_TANK = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_long,
  input  logic [9:0] req_addr,
  output logic [3:0] rack_read,
  output logic [3:0] rack_write,
  output logic       f9_pos,
  output logic [1:0] tank_sel,
  output logic       xfer_gate,
  output logic [4:0] word_pos,
  output logic [4:0] digit_pos,
  output logic       done,
  output logic       err
);

  localparam int XW = $clog2(2 * MINOR_LEN);
  localparam logic [XW-1:0] SHORT_LAST = XW'(MINOR_LEN - 1);
  localparam logic [XW-1:0] LONG_LAST  = XW'(2 * MINOR_LEN - 1);
  localparam logic [4:0]    DIGIT_LAST = 5'(MINOR_LEN - 1);
  localparam logic [4:0]    WORD_LAST  = 5'(WORDS_PER_TANK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      digit_q, digit_d;
  logic [4:0]      word_q, word_d;
  logic [XW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [1:0]      rack_q;
  logic            f9_q;
  logic [1:0]      tank_q;
  logic [4:0]      slot_q;
  logic            write_q;
  logic            long_q;

  logic            digit_wrap;
  logic            accept;
  logic            reject;
  logic            hit_new;
  logic            hit_held;

  // Free-running position counters
  always_comb begin
    digit_wrap = (digit_q == DIGIT_LAST);
    digit_d    = digit_wrap ? 5'd0 : digit_q + 5'd1;
    word_d     = word_q;
    if (digit_wrap) begin
      word_d = (word_q == WORD_LAST) ? 5'd0 : word_q + 5'd1;
    end
  end

  // Slot match is evaluated one clock ahead so that the cycle the counters
  // reach (slot, digit 0) is already the first transfer cycle. hit_new uses
  // the incoming address so a request arriving one clock before its slot
  // goes straight to the transfer.
  assign hit_new  = digit_wrap && (word_d == req_addr[4:0]);
  assign hit_held = digit_wrap && (word_d == slot_q);

  assign accept = req_valid && (state_q == S_IDLE);
  assign reject = accept && req_long && req_addr[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (reject) begin
          err_d = 1'b1;
        end else if (accept) begin
          state_d = hit_new ? S_XFER : S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (hit_held) begin
          state_d = S_XFER;
          cnt_d   = '0;
        end
      end
      S_XFER: begin
        if (cnt_q == (long_q ? LONG_LAST : SHORT_LAST)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      digit_q <= 5'd0;
      word_q  <= 5'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rack_q  <= 2'd0;
      f9_q    <= 1'b0;
      tank_q  <= 2'd0;
      slot_q  <= 5'd0;
      write_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        rack_q  <= req_addr[9:8];
        f9_q    <= req_addr[7];
        tank_q  <= req_addr[6:5];
        slot_q  <= req_addr[4:0];
        write_q <= req_write;
        long_q  <= req_long;
      end
    end
  end

  // Outputs decode registered state only, so reset clears them on the edge
  assign xfer_gate  = (state_q == S_XFER);
  assign rack_read  = (xfer_gate && !write_q) ? (4'b0001 << rack_q) : 4'b0000;
  assign rack_write = (xfer_gate &&  write_q) ? (4'b0001 << rack_q) : 4'b0000;
  assign req_ready  = (state_q == S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign f9_pos     = f9_q;
  assign tank_sel   = tank_q;
  assign word_pos   = word_q;
  assign digit_pos  = digit_q;

endmodule
`default_nettype wire

// File: tb/tb_tank_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tank_access_sequencer
// Description : Directed bench for tank_access_sequencer. A table of access
//               vectors with hand-computed latency, gate length and selects is
//               applied in a loop; reset-mid-transfer and back-to-back
//               requests are written out by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tank_access_sequencer;

  localparam int MINOR = 18;
  localparam int WORDS = 32;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic       req_long;
  logic [9:0] req_addr;
  logic [3:0] rack_read;
  logic [3:0] rack_write;
  logic       f9_pos;
  logic [1:0] tank_sel;
  logic       xfer_gate;
  logic [4:0] word_pos;
  logic [4:0] digit_pos;
  logic       done;
  logic       err;

  tank_access_sequencer #(
    .MINOR_LEN      (MINOR),
    .WORDS_PER_TANK (WORDS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_long   (req_long),
    .req_addr   (req_addr),
    .rack_read  (rack_read),
    .rack_write (rack_write),
    .f9_pos     (f9_pos),
    .tank_sel   (tank_sel),
    .xfer_gate  (xfer_gate),
    .word_pos   (word_pos),
    .digit_pos  (digit_pos),
    .done       (done),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         wr;
    bit         lng;
    logic [9:0] addr;
    int         acc_w;
    int         acc_d;
    bit         illegal;
    logic [3:0] exp_rr;
    logic [3:0] exp_rw;
    bit         exp_f9;
    logic [1:0] exp_tank;
    int         exp_lat;
    int         exp_len;
    logic [4:0] exp_slot;
  } vec_t;

  int n_check = 0;
  int n_pass  = 0;
  int m_cyc   = 0;   // clocks since the last reset edge

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_check++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic int m_digit();
    return m_cyc % MINOR;
  endfunction

  function automatic int m_word();
    return (m_cyc / MINOR) % WORDS;
  endfunction

  // One clock; leaves the bench 1 time unit after the rising edge
  task automatic tick();
    logic r;
    r = rst_n;
    @(posedge clk);
    #1;
    if (!r) m_cyc = 0;
    else    m_cyc++;
  endtask

  task automatic wait_pos(input int w, input int d);
    for (int i = 0; i < 1200 && !(m_word() == w && m_digit() == d); i++) tick();
    chk("position", {word_pos, digit_pos}, {5'(w), 5'(d)});
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int len;
    bit bad;
    wait_pos(v.acc_w, v.acc_d);
    chk("ready_before", req_ready, 1);
    req_valid = 1'b1;
    req_write = v.wr;
    req_long  = v.lng;
    req_addr  = v.addr;
    tick();
    // Garbage on the request inputs must be ignored from here on
    req_valid = 1'b0;
    req_write = ~v.wr;
    req_long  = 1'b0;
    req_addr  = 10'h3FF;
    if (v.illegal) begin
      chk("err_pulse", {err, req_ready, rack_read, rack_write, xfer_gate}, {1'b1, 1'b1, 8'h00, 1'b0});
      tick();
      chk("err_clear", {err, xfer_gate, req_ready}, 3'b001);
      return;
    end
    bad = 0;
    lat = 1;
    while (!xfer_gate && lat < 700) begin
      if (req_ready || rack_read != 0 || rack_write != 0 || done || err) bad = 1;
      tick();
      lat++;
    end
    chk("wait_clean", bad, 0);
    chk("latency", lat, v.exp_lat);
    chk("gate_slot", {word_pos, digit_pos}, {v.exp_slot, 5'd0});
    bad = 0;
    len = 0;
    while (xfer_gate && len < 100) begin
      if (rack_read != v.exp_rr || rack_write != v.exp_rw || f9_pos != v.exp_f9 ||
          tank_sel != v.exp_tank || req_ready || done) bad = 1;
      tick();
      len++;
    end
    chk("gate_sel", bad, 0);
    chk("gate_len", len, v.exp_len);
    chk("done_pulse", {done, xfer_gate, req_ready, rack_read, rack_write}, {1'b1, 1'b0, 1'b0, 8'h00});
    tick();
    chk("idle_after", {done, req_ready}, 2'b01);
    chk("latched_hold", {f9_pos, tank_sel}, {v.exp_f9, v.exp_tank});
  endtask

  vec_t vecs[8];

  initial begin
    int  n;
    bit  bad;
    int  lat;

    //          wr  lng addr     accW accD ill  rr       rw       f9 tank  lat  len slot
    vecs[0] = '{1'b0, 1'b0, 10'h005,  3,  0, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0,  36, 18, 5'd5};
    vecs[1] = '{1'b1, 1'b1, 10'h3C4,  2, 10, 1'b0, 4'b0000, 4'b1000, 1'b1, 2'd2,  26, 36, 5'd4};
    vecs[2] = '{1'b0, 1'b0, 10'h007,  7,  0, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0, 576, 18, 5'd7};
    vecs[3] = '{1'b0, 1'b1, 10'h109,  0,  0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0,   0,  0, 5'd0};
    vecs[4] = '{1'b1, 1'b0, 10'h25F, 30, 17, 1'b0, 4'b0000, 4'b0100, 1'b0, 2'd2,   1, 18, 5'd31};
    vecs[5] = '{1'b0, 1'b1, 10'h1BE, 29,  0, 1'b0, 4'b0010, 4'b0000, 1'b1, 2'd1,  18, 36, 5'd30};
    vecs[6] = '{1'b1, 1'b1, 10'h01F,  0,  0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0,   0,  0, 5'd0};
    vecs[7] = '{1'b0, 1'b0, 10'h2A3,  0,  0, 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd1,  54, 18, 5'd3};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_long  = 1'b0;
    req_addr  = 10'h000;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset_state",
        {req_ready, rack_read, rack_write, xfer_gate, done, err, f9_pos, tank_sel, word_pos, digit_pos},
        {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0});
    tick();
    chk("count_start", {word_pos, digit_pos}, {5'd0, 5'd1});

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a transfer
    wait_pos(3, 0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_long  = 1'b0;
    req_addr  = 10'h005;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!xfer_gate && n < 700) begin tick(); n++; end
    for (int i = 0; i < 10; i++) tick();
    chk("mid_xfer_digit", {xfer_gate, digit_pos}, {1'b1, 5'd10});
    rst_n = 1'b0;
    tick();
    chk("rst_mid_xfer",
        {rack_read, rack_write, xfer_gate, done, word_pos, digit_pos, req_ready},
        {8'h00, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1});
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || xfer_gate) bad = 1;
      tick();
    end
    chk("no_done_after_rst", bad, 0);
    run_vec(vecs[0]);

    // Back-to-back with req_valid held; inputs change while busy
    wait_pos(3, 0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_long  = 1'b0;
    req_addr  = 10'h005;
    tick();
    req_write = 1'b1;
    req_addr  = 10'h3A6;
    bad = 0;
    n = 0;
    while (!done && n < 700) begin
      if (req_ready) bad = 1;
      if (xfer_gate && (rack_read != 4'b0001 || rack_write != 4'b0000 || f9_pos || tank_sel != 2'd0)) bad = 1;
      tick();
      n++;
    end
    chk("b2b_first_busy", bad, 0);
    chk("b2b_first_done", {done, word_pos, digit_pos}, {1'b1, 5'd6, 5'd0});
    tick();
    chk("b2b_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("b2b_second_acc", {req_ready, f9_pos, tank_sel}, {1'b0, 1'b1, 2'd1});
    lat = 1;
    while (!xfer_gate && lat < 700) begin tick(); lat++; end
    chk("b2b_latency", lat, 575);
    chk("b2b_sel", {rack_read, rack_write}, {4'b0000, 4'b1000});
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    chk("b2b_second_done", n, 18);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
`default_nettype wire
